// File: rtl/mandelbrot_scan_gen_if.sv
// Control, status and pipeline-coordinate signals between the frame controller,
// the raster scan generator and the mandelbrot core.
interface mandelbrot_scan_gen_if;
   logic        start;
   logic        abort;
   logic        pause;
   logic        in_enable;
   logic [10:0] xin;
   logic [10:0] yin;
   logic        coord_valid;
   logic        line_start;
   logic        busy;
   logic        done;
   logic [15:0] frame_count;

   modport master (
      input  start, abort, pause, in_enable,
      output xin, yin, coord_valid, line_start, busy, done, frame_count
   );

   modport slave (
      output start, abort, pause, in_enable,
      input  xin, yin, coord_valid, line_start, busy, done, frame_count
   );
endinterface

// File: rtl/mandelbrot_scan_gen.sv
// Raster-order coordinate source for the mandelbrot pipeline: issues x fastest then y,
// retires a coordinate only when the pipeline samples it, then drains and flags completion.
module mandelbrot_scan_gen #(
   parameter int unsigned RESX  = 640,
   parameter int unsigned RESY  = 480,
   parameter int unsigned DRAIN = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mandelbrot_scan_gen_if.master bus
);

   localparam logic [10:0] RESX_M1  = 11'(RESX - 1);
   localparam logic [10:0] RESY_M1  = 11'(RESY - 1);
   localparam logic [7:0]  DRAIN_M1 = 8'(DRAIN - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [10:0] x_q, x_d;
   logic [10:0] y_q, y_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] fc_q, fc_d;
   logic        coord_valid;
   logic        accept;

   assign coord_valid = (state_q == S_SCAN) && !bus.pause;
   assign accept      = coord_valid && bus.in_enable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         cnt_q   <= '0;
         fc_q    <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cnt_q   <= cnt_d;
         fc_q    <= fc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      cnt_d   = cnt_q;
      fc_d    = fc_q;
      unique case (state_q)
         S_IDLE: begin
            x_d = '0;
            y_d = '0;
            if (bus.start && !bus.abort) state_d = S_SCAN;
         end
         S_SCAN: begin
            if (accept) begin
               if (x_q != RESX_M1) begin
                  x_d = x_q + 11'd1;
               end else if (y_q != RESY_M1) begin
                  x_d = '0;
                  y_d = y_q + 11'd1;
               end else begin
                  state_d = S_DRAIN;
                  cnt_d   = DRAIN_M1;
               end
            end
         end
         S_DRAIN: begin
            if (cnt_q == '0) begin
               state_d = S_DONE;
               fc_d    = fc_q + 16'd1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            x_d     = '0;
            y_d     = '0;
         end
         default: state_d = S_IDLE;
      endcase
      // abort overrides everything above except a count already taken on entry to DONE
      if (bus.abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         x_d     = '0;
         y_d     = '0;
         cnt_d   = '0;
         fc_d    = fc_q;
      end
   end

   assign bus.xin         = x_q;
   assign bus.yin         = y_q;
   assign bus.coord_valid = coord_valid;
   assign bus.line_start  = coord_valid && (x_q == '0);
   assign bus.busy        = (state_q == S_SCAN) || (state_q == S_DRAIN);
   assign bus.done        = (state_q == S_DONE);
   assign bus.frame_count = fc_q;

endmodule

// File: doc/mandelbrot_scan_gen.md
Name: mandelbrot_scan_gen

Overview:
- Coordinate source that drives the xin/yin inputs of the mandelbrot pipeline in raster order: x from 0 to RESX-1 fastest, then y from 0 to RESY-1.
- Honours the pipeline's in_enable back-pressure. A coordinate is retired only on a clock edge where the pipeline samples it.
- After the last pixel is issued it waits a fixed drain window, then signals frame completion.
- Sits between the frame controller (start/abort/pause) and the mandelbrot core.

Parameters:
- RESX, 640, frame width in pixels, 11-bit, legal range 1..2047.
- RESY, 480, frame height in pixels, 11-bit, legal range 1..2047.
- DRAIN, 16, number of cycles spent in DRAIN after the last accept, legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a frame; sampled only in IDLE.
- abort  in  1  return to IDLE from any state; no done, no frame count.
- pause  in  1  hold issue while high (SCAN only).
- in_enable  in  1  pipeline ready; a coordinate is consumed at an edge where this is high.
- xin  out  11  current x coordinate, registered.
- yin  out  11  current y coordinate, registered.
- coord_valid  out  1  xin/yin hold a live frame coordinate.
- line_start  out  1  high while xin==0 and coord_valid.
- busy  out  1  state is SCAN or DRAIN.
- done  out  1  one-cycle pulse at frame completion.
- frame_count  out  16  completed frames, wraps at 65535 to 0.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, xin=0, yin=0, drain counter=0, frame_count=0.
  - done=0, busy=0, coord_valid=0.
- States: IDLE, SCAN, DRAIN, DONE.
- accept = (state==SCAN) && !pause && in_enable.
- coord_valid = (state==SCAN) && !pause, combinational.
- IDLE:
  - xin and yin hold 0.
  - start=1 && abort=0 at an edge: go to SCAN; xin=0, yin=0.
- SCAN:
  - On accept with xin<RESX-1: xin+1.
  - On accept with xin==RESX-1 and yin<RESY-1: xin=0, yin+1.
  - On accept with xin==RESX-1 and yin==RESY-1: go to DRAIN; load drain counter=DRAIN-1; xin/yin hold.
  - No accept: xin and yin hold.
  - pause and in_enable low are equivalent for advance.
- DRAIN:
  - Counter decrements every cycle, ignoring pause and in_enable.
  - At counter==0 go to DONE. DRAIN therefore lasts exactly DRAIN cycles.
- DONE:
  - done=1 for this single cycle; frame_count increments on the edge entering DONE.
  - Next edge: go to IDLE; xin=0, yin=0.
  - start during DONE is ignored.
- start in SCAN, DRAIN or DONE is ignored; no restart.
- abort=1 at an edge in any non-IDLE state:
  - Go to IDLE; xin=0, yin=0.
  - No done pulse; frame_count is unchanged.
  - abort beats start in the same cycle.
  - abort in DONE: the increment already happened and is kept; no further pulse.
- RESX=1: every accept advances y. RESX=1, RESY=1: the first accept goes straight to DRAIN.
- Total accepts per completed frame = RESX*RESY exactly; no duplicates, no skips.
- Coordinates are unsigned 11-bit; no arithmetic wider than 11 bits on x/y.
- Counter compare uses the 11-bit parameters directly.

Test Plan:
- Nominal frame, RESX=4, RESY=2, DRAIN=3, in_enable=1, start pulsed at edge 0:
  - Accepts at edges 1..8, sequence (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(3,1).
  - line_start high for the (0,0) and (0,1) cycles.
  - busy high from edge 0 to edge 11; done high only between edges 11 and 12; frame_count=1.
- Back-pressure, same config, in_enable low on alternate cycles plus a 5-cycle pause burst mid-line:
  - Same 8-coordinate sequence, no repeats or skips.
  - done delayed by exactly the number of non-accept cycles.
- Abort in SCAN at coordinate (2,1):
  - Next cycle state IDLE, xin=yin=0, busy=0; no done pulse; frame_count unchanged.
  - A new start restarts from (0,0).
- Abort and start in the same IDLE cycle: stays IDLE, busy=0.
- Start asserted during SCAN and during DONE: ignored, no effect on the sequence.
- Asynchronous reset asserted mid-DRAIN: all outputs 0 immediately, before the next clock edge.
- Degenerate and wrap cases:
  - RESX=1, RESY=1, DRAIN=1: accept at edge 1, done between edges 2 and 3.
  - Preload frame_count=65535 by running frames: next completion gives 0.
